// File: rtl/class_score_accumulator.sv
// Output-layer MAC engine: streams feature beats carrying ten class weights and keeps ten
// signed running sums. At frame close it publishes the ten scores, held, with a one-cycle valid.
module class_score_accumulator #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ACC_W        = 26,
    parameter int unsigned MAX_FEATURES = 784,
    parameter int unsigned CNT_W        = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] in_feature,
    input  logic [10*DATA_W-1:0]     in_weights,
    output logic                     in_ready,
    output logic                     busy,
    output logic signed [ACC_W-1:0]  image_number_0,
    output logic signed [ACC_W-1:0]  image_number_1,
    output logic signed [ACC_W-1:0]  image_number_2,
    output logic signed [ACC_W-1:0]  image_number_3,
    output logic signed [ACC_W-1:0]  image_number_4,
    output logic signed [ACC_W-1:0]  image_number_5,
    output logic signed [ACC_W-1:0]  image_number_6,
    output logic signed [ACC_W-1:0]  image_number_7,
    output logic signed [ACC_W-1:0]  image_number_8,
    output logic signed [ACC_W-1:0]  image_number_9,
    output logic                     out_valid,
    output logic                     err_len
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MAX_FEATURES - 1);

    typedef enum logic [0:0] {StIdle, StAcc} state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q   [10];
    logic signed [ACC_W-1:0]  acc_d   [10];
    logic signed [ACC_W-1:0]  score_q [10];
    logic signed [ACC_W-1:0]  score_d [10];
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic                     err_len_q, err_len_d;
    logic                     frame_close;

    logic signed [PROD_W-1:0] prod [10];
    logic signed [ACC_W-1:0]  sum  [10];

    // Full-precision products, sign-extended into the accumulator width.
    always_comb begin
        for (int k = 0; k < 10; k++) begin
            prod[k] = in_feature * $signed(in_weights[DATA_W*k +: DATA_W]);
            sum[k]  = acc_q[k] + {{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        score_d     = score_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        err_len_d   = err_len_q;
        frame_close = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StAcc;
                    cnt_d     = '0;
                    err_len_d = 1'b0;
                    for (int k = 0; k < 10; k++) acc_d[k] = '0;
                end
            end
            StAcc: begin
                if (start) begin
                    // Abort: any beat presented alongside start is dropped.
                    cnt_d = '0;
                    for (int k = 0; k < 10; k++) acc_d[k] = '0;
                end else if (in_valid) begin
                    frame_close = in_last || (cnt_q == LastCnt);
                    cnt_d       = cnt_q + CNT_W'(1);
                    acc_d       = sum;
                    if (frame_close) begin
                        score_d     = sum;
                        out_valid_d = 1'b1;
                        state_d     = StIdle;
                        err_len_d   = !in_last;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
            for (int k = 0; k < 10; k++) begin
                acc_q[k]   <= '0;
                score_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            err_len_q   <= err_len_d;
            acc_q       <= acc_d;
            score_q     <= score_d;
        end
    end

    assign in_ready       = (state_q == StAcc);
    assign busy           = in_ready;
    assign out_valid      = out_valid_q;
    assign err_len        = err_len_q;
    assign image_number_0 = score_q[0];
    assign image_number_1 = score_q[1];
    assign image_number_2 = score_q[2];
    assign image_number_3 = score_q[3];
    assign image_number_4 = score_q[4];
    assign image_number_5 = score_q[5];
    assign image_number_6 = score_q[6];
    assign image_number_7 = score_q[7];
    assign image_number_8 = score_q[8];
    assign image_number_9 = score_q[9];

endmodule

// File: tb/tb_class_score_accumulator.sv
// Bench for class_score_accumulator: directed scenarios plus random frames, checked every cycle
// against a frame-level model that stores accepted beats and sums them at close.
module tb_class_score_accumulator;

    localparam int DW   = 8;
    localparam int AW   = 26;
    localparam int MAXF = 784;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start, in_valid, in_last;
    logic signed [DW-1:0] in_feature;
    logic [10*DW-1:0]     in_weights;
    logic                 in_ready, busy, out_valid, err_len;
    logic signed [AW-1:0] img [10];

    always #5 clk = ~clk;

    class_score_accumulator dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_last        (in_last),
        .in_feature     (in_feature),
        .in_weights     (in_weights),
        .in_ready       (in_ready),
        .busy           (busy),
        .image_number_0 (img[0]),
        .image_number_1 (img[1]),
        .image_number_2 (img[2]),
        .image_number_3 (img[3]),
        .image_number_4 (img[4]),
        .image_number_5 (img[5]),
        .image_number_6 (img[6]),
        .image_number_7 (img[7]),
        .image_number_8 (img[8]),
        .image_number_9 (img[9]),
        .out_valid      (out_valid),
        .err_len        (err_len)
    );

    int total = 0;
    int bad   = 0;
    int n_pulse = 0;

    // Frame-level model: accepted beats are queued; scores are computed only at close.
    bit          m_open  = 1'b0;
    bit          m_pulse = 1'b0;
    bit          m_err   = 1'b0;
    int          m_score [10];
    int          x_q [$];
    logic [79:0] w_q [$];

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int frame_sum(input int k);
        int s = 0;
        for (int i = 0; i < x_q.size(); i++) begin
            logic [79:0] w = w_q[i];
            logic signed [7:0] wk = w[8*k +: 8];
            s += x_q[i] * int'(wk);
        end
        return s;
    endfunction

    task automatic model_edge(input bit s, input bit v, input bit l, input int x,
                              input logic [79:0] w);
        m_pulse = 1'b0;
        if (!m_open) begin
            if (s) begin
                m_open = 1'b1;
                m_err  = 1'b0;
                x_q.delete();
                w_q.delete();
            end
        end else if (s) begin
            x_q.delete();
            w_q.delete();
        end else if (v) begin
            x_q.push_back(x);
            w_q.push_back(w);
            if (l || x_q.size() == MAXF) begin
                for (int k = 0; k < 10; k++) m_score[k] = frame_sum(k);
                m_pulse = 1'b1;
                m_open  = 1'b0;
                m_err   = !l;
            end
        end
    endtask

    task automatic model_reset();
        m_open  = 1'b0;
        m_pulse = 1'b0;
        m_err   = 1'b0;
        for (int k = 0; k < 10; k++) m_score[k] = 0;
        x_q.delete();
        w_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        int nmis = 0;
        for (int k = 0; k < 10; k++) if (int'(img[k]) != m_score[k]) nmis++;
        check({tag, "/scores_mismatched"}, nmis, 0);
        check({tag, "/out_valid"}, out_valid, m_pulse);
        check({tag, "/in_ready"}, in_ready, m_open);
        check({tag, "/busy"}, busy, m_open);
        check({tag, "/err_len"}, err_len, m_err);
    endtask

    // One clock: apply inputs, step model at the edge, sample #1 later.
    task automatic cyc(input bit s, input bit v, input bit l, input int x, input logic [79:0] w);
        start      = s;
        in_valid   = v;
        in_last    = l;
        in_feature = DW'(x);
        in_weights = w;
        @(posedge clk);
        model_edge(s, v, l, x, w);
        #1;
        if (out_valid) n_pulse++;
        check_outputs("cyc");
    endtask

    function automatic logic [79:0] wconst(input int v);
        logic [79:0] w;
        for (int k = 0; k < 10; k++) w[8*k +: 8] = DW'(v);
        return w;
    endfunction

    logic [79:0] w_idx, w_one, w_ext;
    logic [95:0] rnd;
    int          p0;

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_feature = '0;
        in_weights = '0;
        model_reset();
        for (int k = 0; k < 10; k++) w_idx[8*k +: 8] = DW'(k);
        w_one = wconst(1);
        w_ext = wconst(127);
        w_ext[7:0] = 8'h80;

        #12;
        check_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b1;

        // Beat without start in IDLE is ignored.
        cyc(0, 1, 1, 5, w_one);

        // Basic frame: x = 1,2,3 with w_k = k.
        cyc(1, 0, 0, 0, w_idx);
        cyc(0, 1, 0, 1, w_idx);
        cyc(0, 1, 0, 2, w_idx);
        cyc(0, 1, 1, 3, w_idx);
        check("basic/img9", int'(img[9]), 54);
        check("basic/img1", int'(img[1]), 6);
        check("basic/pulse", out_valid, 1);
        cyc(0, 0, 0, 0, w_idx);
        check("basic/ready_after", in_ready, 0);

        // Extremes over the full length, in_last on the final beat.
        cyc(1, 0, 0, 0, w_ext);
        for (int i = 0; i < MAXF; i++) cyc(0, 1, i == MAXF - 1, -128, w_ext);
        check("ext/img0", int'(img[0]), 12845056);
        check("ext/img9", int'(img[9]), -12744704);
        check("ext/err", err_len, 0);

        // Length limit closes without in_last; the following beat is ignored.
        cyc(1, 0, 0, 0, w_one);
        for (int i = 0; i < MAXF; i++) cyc(0, 1, 0, 1, w_one);
        check("limit/img5", int'(img[5]), 784);
        check("limit/err", err_len, 1);
        cyc(0, 1, 0, 1, w_one);
        check("limit/ready_785", in_ready, 0);

        // Abort then stalled single-beat frame.
        p0 = n_pulse;
        cyc(1, 0, 0, 0, w_one);
        cyc(0, 1, 0, 5, w_one);
        cyc(0, 1, 0, 5, w_one);
        cyc(1, 0, 0, 0, w_one);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, w_one);
        check("abort/held", int'(img[3]), 784);
        cyc(0, 1, 1, 1, w_one);
        check("abort/img3", int'(img[3]), 1);
        check("abort/pulses", n_pulse - p0, 1);

        // start and in_valid together in IDLE: beat dropped.
        cyc(1, 1, 0, 7, w_one);
        cyc(0, 1, 1, 2, w_one);
        check("collide/img0", int'(img[0]), 2);

        // Asynchronous reset mid-frame, between clock edges.
        cyc(1, 0, 0, 0, w_idx);
        cyc(0, 1, 0, 9, w_idx);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs("midreset");
        #2 rst = 1'b1;
        cyc(0, 1, 1, 9, w_idx);

        // Random frames with stalls, aborts and random in_last.
        for (int f = 0; f < 25; f++) begin
            cyc(1, $urandom_range(0, 3) == 0, 0, 3, w_one);
            for (int c = 0; c < 400 && m_open; c++) begin
                int  x;
                bit  v, s, l;
                rnd = {$urandom(), $urandom(), $urandom()};
                x   = int'($urandom_range(0, 255)) - 128;
                v   = $urandom_range(0, 9) < 7;
                s   = $urandom_range(0, 59) == 0;
                l   = $urandom_range(0, 14) == 0;
                cyc(s, v, l, x, rnd[79:0]);
            end
            cyc(0, 1, 0, 4, w_one);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
